frame_capture_writer: RTL and testbench

//  Sits downstream of the game pixel generator. Takes its per-pixel stream (h/v scan position + 12-bit RGB) and,
//  on request, copies exactly one complete visible frame into an external frame memory as compact linear words.
//  A small FIFO decouples the fixed-rate pixel stream from the req/ack memory port. Reports busy, done and overflow.

---
 rtl/frame_capture_writer.sv | 185 ++++++++++++++++++
 tb/tb_frame_capture_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_writer.sv
// rtl/frame_capture_writer.sv - copies one visible frame from the pixel stream into frame memory
module frame_capture_writer #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 19,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [9:0]        pix_h,
    input  logic [9:0]        pix_v,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              capture_start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_written
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int H_LAST_I = H_ACTIVE - 1;
    localparam int V_LAST_I = V_ACTIVE - 1;

    localparam logic [9:0]        H_LIM      = H_ACTIVE[9:0];
    localparam logic [9:0]        V_LIM      = V_ACTIVE[9:0];
    localparam logic [9:0]        H_LAST     = H_LAST_I[9:0];
    localparam logic [9:0]        V_LAST     = V_LAST_I[9:0];
    localparam logic [PTR_W:0]    FULL_COUNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;

    // Each FIFO entry carries its own address so the memory side never recomputes it.
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     wr_ptr_d;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_avail;

    logic               visible;
    logic               is_first;
    logic               is_last;
    logic               push_req;
    logic               push;
    logic               drop;
    logic               load;
    logic               mem_fire;
    logic [ADDR_W-1:0]  pix_addr;

    assign visible  = pix_valid && (pix_h < H_LIM) && (pix_v < V_LIM);
    assign is_first = visible && (pix_h == 10'd0) && (pix_v == 10'd0);
    assign is_last  = visible && (pix_h == H_LAST) && (pix_v == V_LAST);
    assign pix_addr = ADDR_W'(pix_v) * LINE_WORDS + ADDR_W'(pix_h);

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    // Reads only see entries written before the previous edge, giving a fixed two-edge
    // push-to-request latency and keeping the read path off the write port.
    assign fifo_avail = (wr_ptr_d != rd_ptr);

    assign push_req = ((state == ST_ARM) && is_first) || ((state == ST_CAPTURE) && visible);
    assign push     = push_req && !fifo_full;
    assign drop     = push_req && fifo_full;
    assign mem_fire = mem_req && mem_ack;
    assign load     = fifo_avail && (!mem_req || mem_ack);

    // FIFO storage; flushing is done by the pointers, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {pix_addr, pix_data};
        end
    end

    // FIFO pointers, plus a one-edge delayed write pointer for the read side.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            wr_ptr_d <= '0;
            rd_ptr   <= '0;
        end else begin
            wr_ptr_d <= wr_ptr;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Memory output register: holds address/data steady until the memory acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (load) begin
            {mem_addr, mem_data} <= fifo_mem[rd_ptr[PTR_W-1:0]];
            mem_req              <= 1'b1;
        end else if (mem_fire) begin
            mem_req <= 1'b0;
        end
    end

    // Per-capture status: sticky overflow and a saturating acked-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow      <= 1'b0;
            words_written <= '0;
        end else if ((state == ST_IDLE) && capture_start) begin
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (mem_fire && (words_written != '1)) begin
                words_written <= words_written + 1'b1;
            end
        end
    end

    // Capture sequencing with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (capture_start) begin
                        state <= ST_ARM;
                        busy  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (is_first) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (is_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !mem_req) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb/tb_frame_capture_writer.sv - directed self-checking bench for frame_capture_writer
module tb_frame_capture_writer;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 19;
    localparam int H_ACT  = 4;
    localparam int V_ACT  = 3;
    localparam int DEPTH  = 4;
    localparam int FRAME  = H_ACT * V_ACT;

    logic              clk;
    logic              reset;
    logic              pix_valid;
    logic [9:0]        pix_h;
    logic [9:0]        pix_v;
    logic [DATA_W-1:0] pix_data;
    logic              capture_start;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] words_written;

    frame_capture_writer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .H_ACTIVE  (H_ACT),
        .V_ACTIVE  (V_ACT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .pix_h        (pix_h),
        .pix_v        (pix_v),
        .pix_data     (pix_data),
        .capture_start(capture_start),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ack_mode = 0;
    int t_push = 0;
    logic mon_en = 1'b0;

    // monitor-owned records
    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    int rise_q[$];
    int done_cnt = 0;
    int hold_err = 0;
    logic prev_hold = 1'b0;
    logic prev_req = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pix_word(input int h, input int v);
        logic [3:0] h4;
        logic [3:0] v4;
        logic [7:0] hh;
        h4 = h[3:0];
        v4 = v[3:0];
        hh = 8'(h4) * 8'd17;
        return {v4, hh};
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = 1'b0;
            default: mem_ack = ~mem_ack;
        endcase
    endtask

    task automatic drive_pix(input logic v, input int h, input int vv, input logic cs);
        pix_valid = v;
        pix_h = 10'(h);
        pix_v = 10'(vv);
        pix_data = pix_word(h, vv);
        capture_start = cs;
        step();
        pix_valid = 1'b0;
        capture_start = 1'b0;
    endtask

    // Raster including two blanking pixels per line and one blanking line.
    task automatic raster(input int v0, input int cs_v, input int cs_h, input int gap);
        for (int v = v0; v <= V_ACT; v++) begin
            for (int h = 0; h < H_ACT + 2; h++) begin
                if (h == 0 && v == 0) t_push = cyc + 1;
                drive_pix(1'b1, h, v, (v == cs_v && h == cs_h));
                for (int g = 0; g < gap; g++) step();
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("done_timeout_busy", busy, 0);
    endtask

    task automatic check_frame(input int base, input int n);
        int a;
        check("n_writes", wa.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wa.size()) begin
                a = i;
                check("wr_addr", wa[base+i], a);
                check("wr_data", wd[base+i], pix_word(a % H_ACT, a / H_ACT));
            end
        end
    endtask

    task automatic pulse_start();
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
    endtask

    // Observe the memory port between edges: record writes, request rises and hold violations.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_en) begin
            if (prev_hold && (!mem_req || mem_addr != prev_addr || mem_data != prev_data)) hold_err++;
            if (mem_req && !prev_req) rise_q.push_back(cyc);
            if (mem_req && mem_ack) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_data);
            end
            prev_hold = mem_req && !mem_ack;
            prev_req  = mem_req;
            prev_addr = mem_addr;
            prev_data = mem_data;
        end else begin
            prev_hold = 1'b0;
            prev_req  = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        int db;
        int rb;
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_h = '0;
        pix_v = '0;
        pix_data = '0;
        capture_start = 1'b0;
        mem_ack = 1'b0;
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_words", words_written, 0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Full frame, ack tied high; invisible and non-origin pixels while armed are ignored.
        ack_mode = 0;
        wb = wa.size(); db = done_cnt; rb = rise_q.size();
        pulse_start();
        check("t1_busy_arm", busy, 1);
        drive_pix(1'b1, 700, 0, 1'b1);
        drive_pix(1'b1, 0, 500, 1'b0);
        drive_pix(1'b1, 1, 0, 1'b0);
        drive_pix(1'b0, 0, 0, 1'b0);
        step();
        step();
        check("t1_arm_noreq", mem_req, 0);
        check("t1_arm_nowrite", wa.size() - wb, 0);
        check("t1_arm_busy", busy, 1);
        raster(0, -1, -1, 0);
        wait_done(200);
        check("t1_req_seen", rise_q.size() > rb, 1);
        if (rise_q.size() > rb) check("t1_latency", rise_q[rb], t_push + 2);
        check_frame(wb, FRAME);
        check("t1_done_cnt", done_cnt - db, 1);
        check("t1_overflow", overflow, 0);
        check("t1_words", words_written, FRAME);
        check("t1_hold", hold_err, 0);

        // Start requested mid-frame: nothing written until the next frame origin.
        wb = wa.size(); db = done_cnt;
        raster(0, 1, 0, 0);
        check("t2_nowrite", wa.size() - wb, 0);
        check("t2_busy", busy, 1);
        check("t2_noreq", mem_req, 0);
        raster(0, -1, -1, 0);
        wait_done(200);
        check_frame(wb, FRAME);
        check("t2_done_cnt", done_cnt - db, 1);
        check("t2_words", words_written, FRAME);

        // Ack held low through the frame: output reg + 4 FIFO entries survive, rest dropped.
        // A capture_start during CAPTURE must not clear the status.
        ack_mode = 1;
        wb = wa.size(); db = done_cnt;
        pulse_start();
        raster(0, 1, 1, 0);
        check("t3_busy_drain", busy, 1);
        check("t3_req_held", mem_req, 1);
        check("t3_addr_held", mem_addr, 0);
        ack_mode = 0;
        wait_done(200);
        check_frame(wb, 5);
        check("t3_overflow", overflow, 1);
        check("t3_words", words_written, 5);
        check("t3_done_cnt", done_cnt - db, 1);
        check("t3_hold", hold_err, 0);

        // Ack toggling every cycle with a pixel every other cycle.
        ack_mode = 2;
        wb = wa.size(); db = done_cnt;
        pulse_start();
        check("t4_ovf_cleared", overflow, 0);
        raster(0, -1, -1, 1);
        wait_done(300);
        check_frame(wb, FRAME);
        check("t4_overflow", overflow, 0);
        check("t4_words", words_written, FRAME);
        check("t4_hold", hold_err, 0);

        // Reset while words are buffered and a request is pending.
        ack_mode = 1;
        wb = wa.size();
        pulse_start();
        drive_pix(1'b1, 0, 0, 1'b0);
        drive_pix(1'b1, 1, 0, 1'b0);
        drive_pix(1'b1, 2, 0, 1'b0);
        drive_pix(1'b1, 3, 0, 1'b0);
        drive_pix(1'b1, 0, 1, 1'b0);
        step();
        step();
        check("t5_pre_req", mem_req, 1);
        check("t5_pre_busy", busy, 1);
        check("t5_pre_ovf", overflow, 0);
        mon_en = 1'b0;
        reset = 1'b1;
        step();
        check("t5_rst_req", mem_req, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_words", words_written, 0);
        check("t5_rst_addr", mem_addr, 0);
        reset = 1'b0;
        ack_mode = 0;
        step();
        step();
        check("t5_idle_req", mem_req, 0);
        mon_en = 1'b1;
        wb = wa.size(); db = done_cnt;
        pulse_start();
        raster(0, -1, -1, 0);
        wait_done(200);
        check_frame(wb, FRAME);
        check("t5_overflow", overflow, 0);
        check("t5_words", words_written, FRAME);
        check("t5_done_cnt", done_cnt - db, 1);
        check("t5_hold", hold_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
